// File: rtl/steer_branch_if.sv
// Token handshake bundle for the steer operator: condition/data inputs, true/false arms and
// the sticky overflow flag.
interface steer_branch_if #(
    parameter int unsigned N = 16
);
    logic         EN;
    logic         R_COND;
    logic [N-1:0] D_COND;
    logic         R_DATA;
    logic [N-1:0] D_DATA;
    logic         R_OUT_T;
    logic [N-1:0] D_OUT_T;
    logic         R_OUT_F;
    logic [N-1:0] D_OUT_F;
    logic         OVF;

    modport master (
        output EN, R_COND, D_COND, R_DATA, D_DATA,
        input  R_OUT_T, D_OUT_T, R_OUT_F, D_OUT_F, OVF
    );

    modport slave (
        input  EN, R_COND, D_COND, R_DATA, D_DATA,
        output R_OUT_T, D_OUT_T, R_OUT_F, D_OUT_F, OVF
    );
endinterface

// File: rtl/steer_branch.sv
// Dataflow steer: pairs condition and data tokens in FIFO order and forwards the data on the
// true or false arm. Each input has a DEPTH-entry queue with same-cycle bypass when empty.
module steer_branch #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 2
) (
    input logic           CLK,
    input logic           RST,
    steer_branch_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    // Index 0 is the condition queue, index 1 the data queue.
    logic [N-1:0]  mem_q [2][DEPTH];
    logic [PW-1:0] rd_q  [2];
    logic [PW-1:0] wr_q  [2];
    logic [CW-1:0] cnt_q [2];

    logic          arr_v [2];
    logic [N-1:0]  arr_d [2];
    logic          empty [2];
    logic          full  [2];
    logic          avail [2];
    logic [N-1:0]  head  [2];
    logic          pop   [2];
    logic          push  [2];
    logic          drop  [2];
    logic          match;
    logic          cond_true;

    logic          r_t_q;
    logic          r_f_q;
    logic [N-1:0]  d_t_q;
    logic [N-1:0]  d_f_q;
    logic          ovf_q;

    always_comb begin
        arr_v[0] = bus.R_COND;
        arr_d[0] = bus.D_COND;
        arr_v[1] = bus.R_DATA;
        arr_d[1] = bus.D_DATA;
        for (int i = 0; i < 2; i++) begin
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == FullCnt);
            avail[i] = !empty[i] || arr_v[i];
            // An empty queue exposes this cycle's arrival as its head.
            head[i]  = empty[i] ? arr_d[i] : mem_q[i][rd_q[i]];
        end
        match     = bus.EN && avail[0] && avail[1];
        cond_true = |head[0];
        for (int i = 0; i < 2; i++) begin
            pop[i]  = match && !empty[i];
            // A bypassed arrival is consumed directly and never enters the queue.
            push[i] = bus.EN && arr_v[i] && !(match && empty[i]) && (!full[i] || pop[i]);
            drop[i] = bus.EN && arr_v[i] && full[i] && !pop[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            r_t_q <= 1'b0;
            r_f_q <= 1'b0;
            d_t_q <= '0;
            d_f_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pop[i]) begin
                    rd_q[i] <= rd_q[i] + PW'(1);
                end
                if (push[i]) begin
                    wr_q[i] <= wr_q[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (pop[i] && !push[i]) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
            r_t_q <= match && cond_true;
            r_f_q <= match && !cond_true;
            if (match && cond_true) begin
                d_t_q <= head[1];
            end
            if (match && !cond_true) begin
                d_f_q <= head[1];
            end
            if (drop[0] || drop[1]) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_q[i]] <= arr_d[i];
            end
        end
    end

    assign bus.R_OUT_T = r_t_q;
    assign bus.R_OUT_F = r_f_q;
    assign bus.D_OUT_T = d_t_q;
    assign bus.D_OUT_F = d_f_q;
    assign bus.OVF     = ovf_q;
endmodule

// File: tb/tb_steer_branch.sv
// Bench for steer_branch: a queue-based token model checked every cycle, plus directed
// literal expectations for the documented scenarios.
module tb_steer_branch;
    localparam int unsigned N     = 16;
    localparam int unsigned DEPTH = 2;

    logic CLK = 1'b0;
    logic RST;

    steer_branch_if #(.N(N)) bus ();

    steer_branch #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Token-level model: two FIFOs of pending tokens, pairing in arrival order.
    logic [N-1:0] mcq[$];
    logic [N-1:0] mdq[$];
    logic         e_rt, e_rf, e_ovf;
    logic [N-1:0] e_dt, e_df;
    logic [N-1:0] mc, md;
    bit           c_used, d_used, started = 0;

    always @(posedge CLK) begin
        started = 1;
        if (RST) begin
            mcq.delete();
            mdq.delete();
            e_rt = 0; e_rf = 0; e_dt = '0; e_df = '0; e_ovf = 0;
        end else if (!bus.EN) begin
            e_rt = 0; e_rf = 0;
        end else begin
            e_rt = 0; e_rf = 0; c_used = 0; d_used = 0;
            if ((mcq.size() > 0 || bus.R_COND) && (mdq.size() > 0 || bus.R_DATA)) begin
                if (mcq.size() > 0) mc = mcq.pop_front();
                else begin mc = bus.D_COND; c_used = 1; end
                if (mdq.size() > 0) md = mdq.pop_front();
                else begin md = bus.D_DATA; d_used = 1; end
                if (mc != 0) begin e_rt = 1; e_dt = md; end
                else begin e_rf = 1; e_df = md; end
            end
            if (bus.R_COND && !c_used) begin
                if (mcq.size() < DEPTH) mcq.push_back(bus.D_COND);
                else e_ovf = 1;
            end
            if (bus.R_DATA && !d_used) begin
                if (mdq.size() < DEPTH) mdq.push_back(bus.D_DATA);
                else e_ovf = 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            check("model_r_out_t", 32'(bus.R_OUT_T), 32'(e_rt));
            check("model_r_out_f", 32'(bus.R_OUT_F), 32'(e_rf));
            check("model_d_out_t", 32'(bus.D_OUT_T), 32'(e_dt));
            check("model_d_out_f", 32'(bus.D_OUT_F), 32'(e_df));
            check("model_ovf",     32'(bus.OVF),     32'(e_ovf));
        end
    end

    task automatic cyc(input logic en, input logic rc, input logic [N-1:0] dc,
                       input logic rd, input logic [N-1:0] dd);
        @(negedge CLK);
        bus.EN = en; bus.R_COND = rc; bus.D_COND = dc; bus.R_DATA = rd; bus.D_DATA = dd;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        RST = 1'b1;
        bus.EN = 1'b1; bus.R_COND = 1'b0; bus.D_COND = '0; bus.R_DATA = 1'b0; bus.D_DATA = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("reset_r_out_t", 32'(bus.R_OUT_T), 32'h0);
        check("reset_d_out_t", 32'(bus.D_OUT_T), 32'h0);
        check("reset_ovf",     32'(bus.OVF),     32'h0);

        // Same-cycle pair.
        cyc(1, 1, 16'h0001, 1, 16'h00AA);
        idle();
        check("pair_r_out_t", 32'(bus.R_OUT_T), 32'h1);
        check("pair_d_out_t", 32'(bus.D_OUT_T), 32'h00AA);
        check("pair_r_out_f", 32'(bus.R_OUT_F), 32'h0);
        idle();
        check("pair_pulse_end", 32'(bus.R_OUT_T), 32'h0);

        // Skewed arrival: condition waits three cycles for its data.
        cyc(1, 1, 16'h0000, 0, '0);
        idle();
        idle();
        cyc(1, 0, '0, 1, 16'h1234);
        idle();
        check("skew_r_out_f", 32'(bus.R_OUT_F), 32'h1);
        check("skew_d_out_f", 32'(bus.D_OUT_F), 32'h1234);
        check("skew_d_out_t", 32'(bus.D_OUT_T), 32'h00AA);

        // Streaming with alternating conditions.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, (i % 2 == 0) ? 16'(i + 1) : 16'h0, 1, 16'(i + 1));
        end
        idle();
        check("stream_last_f", 32'(bus.D_OUT_F), 32'h8);
        check("stream_last_t", 32'(bus.D_OUT_T), 32'h7);
        check("stream_ovf",    32'(bus.OVF),     32'h0);

        // Full data queue that pops while accepting a new arrival.
        cyc(1, 0, '0, 1, 16'h0005);
        cyc(1, 0, '0, 1, 16'h0006);
        cyc(1, 1, 16'h0001, 1, 16'h0007);
        idle();
        check("fullpop_d_out_t", 32'(bus.D_OUT_T), 32'h5);
        check("fullpop_ovf",     32'(bus.OVF),     32'h0);
        cyc(1, 1, 16'h0001, 0, '0);
        cyc(1, 1, 16'h0001, 0, '0);
        check("fullpop_second", 32'(bus.D_OUT_T), 32'h6);
        idle();
        check("fullpop_third", 32'(bus.D_OUT_T), 32'h7);

        // Disabled pair is ignored entirely.
        cyc(0, 1, 16'h0001, 1, 16'h0077);
        cyc(1, 0, '0, 1, 16'h0099);
        check("en0_no_t", 32'(bus.R_OUT_T), 32'h0);
        check("en0_no_f", 32'(bus.R_OUT_F), 32'h0);
        cyc(1, 1, 16'h0000, 0, '0);
        idle();
        check("en0_after_f", 32'(bus.D_OUT_F), 32'h0099);

        // Overflow on the data queue.
        cyc(1, 0, '0, 1, 16'h0001);
        cyc(1, 0, '0, 1, 16'h0002);
        cyc(1, 0, '0, 1, 16'h0003);
        idle();
        check("ovf_set", 32'(bus.OVF), 32'h1);
        cyc(1, 1, 16'h0001, 0, '0);
        cyc(1, 1, 16'h0001, 0, '0);
        check("ovf_first", 32'(bus.D_OUT_T), 32'h1);
        idle();
        check("ovf_second", 32'(bus.D_OUT_T), 32'h2);
        check("ovf_sticky", 32'(bus.OVF), 32'h1);

        // Reset discards a queued data token.
        cyc(1, 0, '0, 1, 16'h0042);
        @(negedge CLK);
        RST = 1'b1;
        bus.R_DATA = 1'b0; bus.D_DATA = '0;
        @(negedge CLK);
        RST = 1'b0;
        cyc(1, 1, 16'h0001, 0, '0);
        idle();
        check("rst_no_t",    32'(bus.R_OUT_T), 32'h0);
        check("rst_d_out_t", 32'(bus.D_OUT_T), 32'h0);
        check("rst_d_out_f", 32'(bus.D_OUT_F), 32'h0);
        check("rst_ovf",     32'(bus.OVF),     32'h0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/steer_branch.md
# steer_branch

Dataflow steer operator: the consumer of comparison tokens such as equality results. It pairs a condition token with a data token and forwards the data on the true or false output port. Each input has a small token queue, so the two operands may arrive in different cycles. It sits downstream of the compare operators in the dataflow graph and feeds the branch arms of the parsed program.

## Interface
- N, 16: data and condition token width.
- DEPTH, 2: per-input queue depth in tokens; power of two, ≥ 2.

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  operator enable; low freezes the block.
- R_COND  in  1  condition token valid, one token per cycle high.
- D_COND  in  N  condition value; any nonzero bit means true.
- R_DATA  in  1  data token valid, one token per cycle high.
- D_DATA  in  N  data value.
- R_OUT_T  out  1  true-arm token valid, registered.
- D_OUT_T  out  N  true-arm data, registered.
- R_OUT_F  out  1  false-arm token valid, registered.
- D_OUT_F  out  N  false-arm data, registered.
- OVF  out  1  sticky overflow flag; a token was dropped.

## Operation
- Each input has a FIFO of DEPTH entries with a pointer and count. The count range is 0..DEPTH.
- Effective head, per input:
  - the queue head if the queue is non-empty;
  - otherwise the token arriving this cycle (bypass).
- Match: a match occurs in a cycle when both effective heads exist and EN=1. On a match:
  - pop both queued heads, or consume the bypassed arrivals;
  - if D_COND head ≠ 0, load D_OUT_T with the data head and set R_OUT_T=1, R_OUT_F=0;
  - otherwise load D_OUT_F with the data head and set R_OUT_F=1, R_OUT_T=0.
- Arrival not consumed by bypass: push into its queue.
  - Push and pop in the same cycle are both legal. A full queue that pops accepts the new arrival.
- Overflow: an arrival to a full queue that is not popping that cycle is dropped. OVF is set to 1 and stays 1 until RST.
- No match: R_OUT_T and R_OUT_F go to 0 at the next edge. Both D_OUT registers hold.
- The D_OUT register of the non-selected arm always holds its previous value.
- EN=0:
  - queues are frozen;
  - arrivals are ignored and are not counted as overflow;
  - R_OUT_T and R_OUT_F go to 0 at the next edge;
  - D_OUT_T, D_OUT_F and OVF hold.
- Pairing is strictly FIFO-ordered: the k-th condition token pairs with the k-th data token.

## Timing
- Reset values: R_OUT_T=0, R_OUT_F=0, D_OUT_T=0, D_OUT_F=0, OVF=0, both queues empty.
- RST has priority over EN. RST mid-operation discards all queued tokens.
- Latency:
  - Simultaneous arrivals at edge t produce R_OUT_x high during cycle t+1.
  - A token waiting in a queue is output the cycle after its partner arrives.
- Throughput: one pair per cycle, sustained.
- R_OUT_x is a one-cycle pulse per token. Back-to-back matches keep it high for consecutive cycles, with D_OUT_x updated each cycle.
- R_OUT_T and R_OUT_F are never high in the same cycle.
- Queue pointers wrap modulo DEPTH. Count never exceeds DEPTH.

## Test plan
- Reset, then same-cycle pair COND=1, DATA=0x00AA → next cycle R_OUT_T=1, D_OUT_T=0x00AA, R_OUT_F=0. Following cycle R_OUT_T=0.
- Skewed arrival: COND=0 at t, DATA=0x1234 at t+3 → R_OUT_F=1 with D_OUT_F=0x1234 only in cycle t+4, and D_OUT_T unchanged.
- Streaming: 8 back-to-back pairs with alternating conditions and data 1..8 → outputs alternate T/F every cycle, order preserved, OVF=0.
- Overflow (DEPTH=2): 3 DATA tokens 0x1, 0x2, 0x3 with no COND → OVF=1 after the third. Then 2 COND=1 tokens → R_OUT_T carries 0x1 then 0x2. OVF stays 1.
- Full queue with simultaneous pop: queue DATA=0x5, 0x6, then present COND=1 together with DATA=0x7 → 0x5 emitted, 0x7 queued, OVF=0.
- EN/RST: hold EN=0 while presenting a pair → no output, queues unchanged. Queue one DATA token, assert RST, then send a COND → no output, all outputs 0.
